adc_frame_builder: RTL and testbench

ADC_FRAME_BUILDER -- requirements
Module: adc_frame_builder

---
 rtl/adc_frame_builder.sv | 174 +++++++++++++++++
 tb/tb_adc_frame_builder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_builder.sv
// Builds framed ADC sample records (header, event number, samples, trailer) for a
// downstream USB FIFO, with samples buffered in an internal FIFO while Hold is high.
module adc_frame_builder #(
    parameter int          FIFO_AW = 8,
    parameter logic [15:0] HEADER  = 16'hADCA
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        StartAcq,
    input  logic        Hold,
    input  logic [15:0] AdcData,
    input  logic        AdcData_en,
    input  logic        OutFull,
    output logic [15:0] OutData,
    output logic        OutData_en,
    output logic        FrameBusy,
    output logic [15:0] EventCount
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_EVENT   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_TRAILER = 3'd4;

    logic              r_hold_s1;
    logic              r_hold_s2;
    logic              r_hold_s3;
    logic [2:0]        r_state;
    logic              r_win;
    logic [15:0]       r_mem [DEPTH];
    logic [FIFO_AW:0]  r_wr_ptr;
    logic [FIFO_AW:0]  r_rd_ptr;
    logic [10:0]       r_cnt;
    logic              r_ovf;
    logic [15:0]       r_evt_cnt;
    logic [15:0]       r_out_data;
    logic              r_out_en;

    logic              w_hold_rise;
    logic              w_hold_fall;
    logic              w_open;
    logic              w_close;
    logic [FIFO_AW:0]  w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_sample;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_wr;
    logic [15:0]       w_word;
    logic [2:0]        w_state_nx;

    assign w_hold_rise = r_hold_s2 & ~r_hold_s3;
    assign w_hold_fall = ~r_hold_s2 & r_hold_s3;
    assign w_open      = (r_state == S_IDLE) & w_hold_rise & StartAcq;
    assign w_close     = w_hold_fall | ~StartAcq;

    // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_level == '0);
    assign w_full   = w_level[FIFO_AW];
    assign w_sample = AdcData_en & (r_win | w_open) & ~w_close;
    assign w_push   = w_sample & ~w_full;
    assign w_drop   = w_sample & w_full;

    always_comb begin
        w_state_nx = r_state;
        w_wr       = 1'b0;
        w_word     = HEADER;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_open) w_state_nx = S_HEADER;
            end
            S_HEADER: begin
                if (!OutFull) begin
                    w_wr       = 1'b1;
                    w_word     = HEADER;
                    w_state_nx = S_EVENT;
                end
            end
            S_EVENT: begin
                if (!OutFull) begin
                    w_wr       = 1'b1;
                    w_word     = r_evt_cnt;
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_empty) begin
                    if (!OutFull) begin
                        w_wr   = 1'b1;
                        w_pop  = 1'b1;
                        w_word = r_mem[r_rd_ptr[FIFO_AW-1:0]];
                    end
                end else if (!r_win) begin
                    w_state_nx = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (!OutFull) begin
                    w_wr       = 1'b1;
                    w_word     = {4'hE, r_ovf, r_cnt};
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_s1 <= 1'b0;
            r_hold_s2 <= 1'b0;
            r_hold_s3 <= 1'b0;
        end else begin
            r_hold_s1 <= Hold;
            r_hold_s2 <= r_hold_s1;
            r_hold_s3 <= r_hold_s2;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_win     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_evt_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_open)
                r_win <= 1'b1;
            else if (w_close)
                r_win <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // A sample arriving in the opening cycle is counted as the first one.
            if (w_open) begin
                r_cnt <= w_push ? 11'd1 : 11'd0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push && r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
                if (w_drop) r_ovf <= 1'b1;
            end
            if (r_state == S_TRAILER && w_wr) r_evt_cnt <= r_evt_cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= AdcData;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_en   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_out_en <= w_wr;
            if (w_wr) r_out_data <= w_word;
        end
    end

    assign OutData    = r_out_data;
    assign OutData_en = r_out_en;
    assign FrameBusy  = (r_state != S_IDLE);
    assign EventCount = r_evt_cnt;

endmodule

// File: tb/tb_adc_frame_builder.sv
// Scoreboard bench for adc_frame_builder: directed frames push expected words,
// a monitor pops and compares each OutData_en strobe.
module tb_adc_frame_builder;
    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StartAcq = 1'b0;
    logic        Hold = 1'b0;
    logic [15:0] AdcData = '0;
    logic        AdcData_en = 1'b0;
    logic        OutFull = 1'b0;
    logic [15:0] OutData;
    logic        OutData_en;
    logic        FrameBusy;
    logic [15:0] EventCount;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        full_at_edge = 1'b0;
    logic        busy_seen;

    adc_frame_builder #(.FIFO_AW(8), .HEADER(16'hADCA)) dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .StartAcq   (StartAcq),
        .Hold       (Hold),
        .AdcData    (AdcData),
        .AdcData_en (AdcData_en),
        .OutFull    (OutFull),
        .OutData    (OutData),
        .OutData_en (OutData_en),
        .FrameBusy  (FrameBusy),
        .EventCount (EventCount)
    );

    always #5 Clk = ~Clk;

    // OutFull as seen by the DUT at each rising edge (inputs change on falling edges).
    always @(posedge Clk) full_at_edge <= OutFull;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (reset_n && OutData_en) begin
            if (full_at_edge) begin
                n_checks++;
                $display("FAIL strobe_while_full: word %h written while OutFull was 1", OutData);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h, expected no strobe", OutData);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_word", OutData, mon_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [15:0] d);
        AdcData    = d;
        AdcData_en = 1'b1;
        @(negedge Clk);
        AdcData_en = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge Clk);
            if (!FrameBusy && exp_q.size() == 0) break;
        end
        if (k >= budget) begin
            n_checks++;
            $display("FAIL frame_timeout: busy=%0d, %0d words outstanding, expected 0", FrameBusy, exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_outdata", OutData, 16'h0000);
        chk("rst_outen", {15'd0, OutData_en}, 16'h0000);
        chk("rst_busy", {15'd0, FrameBusy}, 16'h0000);
        chk("rst_evcnt", EventCount, 16'h0000);
        reset_n  = 1'b1;
        StartAcq = 1'b1;
        tick(2);

        // Frame 1: three samples
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0123); exp_q.push_back(16'h0456);
        exp_q.push_back(16'h0789); exp_q.push_back(16'hE003);
        Hold = 1'b1;
        tick(5);
        chk("busy_mid", {15'd0, FrameBusy}, 16'h0001);
        send(16'h0123); send(16'h0456); send(16'h0789);
        Hold = 1'b0;
        wait_done(100);
        chk("evcnt_f1", EventCount, 16'h0001);

        // Frame 2: Hold re-rises while trailer is stalled
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0123); exp_q.push_back(16'h0456);
        exp_q.push_back(16'h0789); exp_q.push_back(16'hE003);
        Hold = 1'b1;
        tick(5);
        send(16'h0123); send(16'h0456); send(16'h0789);
        tick(3);
        OutFull = 1'b1;
        Hold    = 1'b0;
        tick(5);
        Hold = 1'b1;
        tick(6);
        Hold = 1'b0;
        tick(4);
        OutFull = 1'b0;
        wait_done(100);
        chk("evcnt_f2", EventCount, 16'h0002);
        tick(10);
        chk("no_extra_hdr", 16'(exp_q.size()), 16'h0000);

        // Acquisition disabled: nothing happens
        StartAcq  = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            Hold       = ((i / 10) % 2) == 0;
            AdcData    = 16'(16'h0F00 + i);
            AdcData_en = (i % 2) == 1;
            @(negedge Clk);
            busy_seen = busy_seen | FrameBusy;
        end
        Hold       = 1'b0;
        AdcData_en = 1'b0;
        tick(6);
        chk("noacq_busy", {15'd0, busy_seen}, 16'h0000);
        chk("noacq_evcnt", EventCount, 16'h0002);
        StartAcq = 1'b1;
        tick(2);

        // Frame 3: OutFull stall for 20 cycles mid-drain
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0002);
        for (int i = 1; i <= 6; i++) exp_q.push_back(16'(16'h0A00 + i));
        exp_q.push_back(16'hE006);
        Hold = 1'b1;
        tick(5);
        send(16'h0A01); send(16'h0A02);
        OutFull = 1'b1;
        send(16'h0A03); send(16'h0A04); send(16'h0A05); send(16'h0A06);
        tick(12);
        OutFull = 1'b0;
        Hold    = 1'b0;
        wait_done(200);
        chk("evcnt_f3", EventCount, 16'h0003);

        // Frame 4: overflow with OutFull held through the collect window
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0003);
        for (int i = 0; i < 256; i++) exp_q.push_back(16'(i * 3));
        exp_q.push_back(16'hE900);
        OutFull = 1'b1;
        Hold    = 1'b1;
        tick(5);
        for (int i = 0; i < 300; i++) begin
            AdcData    = 16'(i * 3);
            AdcData_en = 1'b1;
            @(negedge Clk);
        end
        AdcData_en = 1'b0;
        Hold       = 1'b0;
        tick(5);
        chk("ovf_held_busy", {15'd0, FrameBusy}, 16'h0001);
        OutFull = 1'b0;
        wait_done(2000);
        chk("evcnt_f4", EventCount, 16'h0004);

        // Frame 5: reset after two samples
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0111); exp_q.push_back(16'h0222);
        Hold = 1'b1;
        tick(5);
        send(16'h0111); send(16'h0222);
        tick(5);
        chk("pre_rst_words", 16'(exp_q.size()), 16'h0000);
        reset_n = 1'b0;
        Hold    = 1'b0;
        tick(2);
        chk("midrst_outdata", OutData, 16'h0000);
        chk("midrst_outen", {15'd0, OutData_en}, 16'h0000);
        chk("midrst_busy", {15'd0, FrameBusy}, 16'h0000);
        chk("midrst_evcnt", EventCount, 16'h0000);
        reset_n = 1'b1;
        tick(3);

        // Frame 6: clean frame after reset, no stale samples or trailer
        exp_q.push_back(16'hADCA); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0BEE); exp_q.push_back(16'hE001);
        Hold = 1'b1;
        tick(5);
        send(16'h0BEE);
        Hold = 1'b0;
        wait_done(100);
        chk("evcnt_f6", EventCount, 16'h0001);
        tick(10);
        chk("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
